fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction-fetch front end that feeds the decode stage.
- Owns the PC register and issues requests to instruction memory, with one request outstanding at a time.
- Buffers returned instructions in a small FIFO and presents them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute, flushes wrong-path work, and stops fetching after a HALT opcode.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
QDEPTH, 2, instruction FIFO depth in entries (power of two, at least 2).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
imem_req  output  1  fetch request valid.
imem_addr  output  16  fetch address; equals current PC.
imem_gnt  input  1  memory accepts the request this cycle.
imem_rvalid  input  1  response data valid.
imem_rdata  input  16  returned instruction.
redirect  input  1  branch/jump taken; flush and refetch.
redirect_pc  input  16  new PC; bit 0 is forced to 0.
if_valid  output  1  FIFO head valid.
if_instr  output  16  FIFO head instruction.
if_pc  output  16  address of the head instruction.
if_pc_next  output  16  if_pc + 2, modulo 2^16.
id_ready  input  1  decode consumes the head this cycle.
halted  output  1  HALT fetched; no further requests.
err  output  1  sticky protocol error.

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC, state=FETCH, FIFO empty.
  - All outputs at reset: if_valid=0, imem_req=0, halted=0, err=0; if_instr, if_pc and if_pc_next read 0.
- State register is 2 bits: FETCH, WAIT, DRAIN, HALTED.
  - An illegal encoding sets err and moves to FETCH on the next clock.
- FETCH:
  - imem_req=1 iff (occupancy < QDEPTH) and redirect=0. This is combinational.
  - On imem_req & imem_gnt: pc <= pc+2 (0xFFFE wraps to 0x0000), go to WAIT.
- WAIT: imem_req=0. On imem_rvalid, push {imem_rdata, requesting pc} into the FIFO.
  - If imem_rdata[15:11]==5'b00000, go to HALTED; otherwise go to FETCH.
  - Minimum issue interval is 2 cycles per instruction.
- HALTED: imem_req=0, halted=1. The FIFO keeps draining to decode.
- DRAIN: imem_req=0. The next imem_rvalid is discarded, then the block goes to FETCH.
- FIFO handshake:
  - Head outputs come from registered storage, with no combinational path from imem_rdata.
  - Pop when if_valid & id_ready.
  - Push and pop in the same cycle are legal. Because occupancy counts the in-flight request, overflow is impossible.
- Redirect has the highest priority in every state. In the same cycle:
  - The FIFO is cleared (the entry decode consumes this cycle is still popped).
  - pc <= {redirect_pc[15:1],1'b0}, and halted clears.
  - Next state is DRAIN if a request is outstanding and its response has not arrived this cycle; otherwise FETCH.
  - An imem_rvalid arriving in the redirect cycle is discarded.
  - imem_req is forced to 0 in the redirect cycle, so no new wrong-path request is issued.
- err (sticky, cleared only by reset) is set on any of:
  - imem_rvalid while in FETCH or HALTED;
  - imem_gnt while imem_req=0;
  - an illegal state encoding.
- Reset mid-transaction: all state is dropped immediately. A stale imem_rvalid arriving after reset release, while in FETCH, sets err; the memory must be reset together with this block.

Test Plan:
- Streaming: imem grants immediately and responds 1 cycle later with 0x1234, 0x5678, 0x9ABC; id_ready=1. Required: decode sees if_pc 0x0000/0x0002/0x0004 in order, if_pc_next = if_pc+2, and one instruction every 2 cycles.
- Backpressure: id_ready=0 for 10 cycles. Required: after 2 instructions are buffered imem_req stays 0, no entry is lost, and order is preserved when id_ready returns to 1.
- Redirect in WAIT: redirect_pc=0x0041 with the response pending. Required: next imem_rvalid data is dropped, the next request has imem_addr=0x0040, and the FIFO was empty the cycle after the redirect.
- Halt: response 0x0000 at pc 0x0010. Required: the HALT entry reaches decode, halted=1, imem_req stays 0 for 20 cycles; a later redirect to 0x0100 clears halted and fetches 0x0100.
- Wrap and error: RESET_PC=0xFFFE. Required: second fetch address is 0x0000. Then drive imem_rvalid in FETCH. Required: err=1 and it stays 1 until rst=0.
- Async reset mid-WAIT: assert rst=0 between clock edges. Required: if_valid=0 and imem_req=0 immediately, and after release imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. Owns the PC, keeps a single
// request outstanding to instruction memory, buffers responses in a small
// FIFO and hands them to decode over valid/ready. Redirects flush wrong-path
// work; a HALT opcode (rdata[15:11] == 0) stops further fetching.
module fetch_queue #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_next,
  input  logic        id_ready,
  output logic        halted,
  output logic        err
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [AW+1:0] QDEPTH_W = QDEPTH[AW+1:0];

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_WAIT   = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [15:0] pc;
  logic [15:0] req_pc;
  logic [15:0] fifo_instr [QDEPTH];
  logic [15:0] fifo_pc    [QDEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [AW+1:0] occ;
  logic        push, pop, err_set, outstanding, fire;

  // occupancy includes the request in flight so a full FIFO never gets
  // a response it cannot store
  assign count       = wr_ptr - rd_ptr;
  assign occ         = {1'b0, count} + {{(AW+1){1'b0}}, (state == S_WAIT)};
  assign outstanding = (state == S_WAIT) || (state == S_DRAIN);
  assign if_valid    = (wr_ptr != rd_ptr);
  assign pop         = if_valid && id_ready;
  assign fire        = imem_req && imem_gnt;
  assign imem_addr   = pc;
  assign halted      = (state == S_HALTED);

  // head comes straight from storage; gated so an empty queue reads zero
  assign if_instr   = if_valid ? fifo_instr[rd_ptr[AW-1:0]] : 16'h0000;
  assign if_pc      = if_valid ? fifo_pc[rd_ptr[AW-1:0]]    : 16'h0000;
  assign if_pc_next = if_valid ? (fifo_pc[rd_ptr[AW-1:0]] + 16'd2) : 16'h0000;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_nx;
  end

  // next state, request, push and error detection; redirect overrides all
  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    push     = 1'b0;
    err_set  = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = rst && !redirect && (occ < QDEPTH_W);
        if (imem_rvalid) err_set = 1'b1;
        if (imem_req && imem_gnt) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          push     = 1'b1;
          state_nx = (imem_rdata[15:11] == 5'b00000) ? S_HALTED : S_FETCH;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) state_nx = S_FETCH;
      end
      S_HALTED: begin
        if (imem_rvalid) err_set = 1'b1;
      end
      default: begin
        err_set  = 1'b1;
        state_nx = S_FETCH;
      end
    endcase
    if (imem_gnt && !imem_req) err_set = 1'b1;
    if (redirect) begin
      push     = 1'b0;
      state_nx = (outstanding && !imem_rvalid) ? S_DRAIN : S_FETCH;
    end
  end

  // PC and the address of the request in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= RESET_PC;
      req_pc <= 16'h0000;
    end else if (redirect) begin
      pc <= {redirect_pc[15:1], 1'b0};
    end else if (fire) begin
      req_pc <= pc;
      pc     <= pc + 16'd2;
    end
  end

  // instruction FIFO; a redirect empties it, including the entry popped now
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        fifo_instr[i] <= 16'h0000;
        fifo_pc[i]    <= 16'h0000;
      end
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        fifo_instr[wr_ptr[AW-1:0]] <= imem_rdata;
        fifo_pc[wr_ptr[AW-1:0]]    <= req_pc;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // sticky protocol error, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

endmodule
